alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the combinational `alu`.
- Captures each accepted ALU result (`y` plus the C/V/Z/N flags and the op code) into a small FIFO, then presents it to the consumer over a valid/ready handshake.
- Maintains sticky carry/overflow status and a saturating overflow-event counter for software/debug visibility.
- Decouples the ALU from consumer backpressure.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 25 ++
 rtl/alu_sync_fifo.sv | 38 +++
 rtl/alu_result_stage.sv | 54 +++++
 tb/tb_alu_result_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag layout and flag packing shared by the ALU and its result stage
package alu_pkg;
  localparam int FLAG_W = 4;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z, input logic v, input logic c);
    logic [FLAG_W-1:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational add/sub with carry (no-borrow on sub), overflow, zero and negative flags
module alu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  logic             sub;
  logic [WIDTH-1:0] bo;
  logic [WIDTH:0]   s;
  assign sub      = op == OP_SUB;
  assign bo       = sub ? ~b : b;
  assign s        = {1'b0, a} + {1'b0, bo} + {{WIDTH{1'b0}}, sub};
  assign y        = s[WIDTH-1:0];
  assign carry    = s[WIDTH];
  assign overflow = (a[WIDTH-1] == bo[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
  assign zero     = y == '0;
  assign negative = y[WIDTH-1];
endmodule

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: valid/ready FIFO with extra-MSB pointers; head reads zero when empty
module alu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop, empty, full;
  assign empty     = wr_ptr == rd_ptr;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results for a valid/ready consumer and tracks sticky C/V plus a saturating overflow count
module alu_result_stage import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [WIDTH-1:0]  in_y,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic              in_zero,
  input  logic              in_negative,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [WIDTH-1:0]  out_y,
  output logic [FLAG_W-1:0] out_flags,
  output logic              sticky_c,
  output logic              sticky_v,
  output logic [CNT_W-1:0]  ovf_count,
  input  logic              sticky_clr
);
  localparam int DW = 4 + WIDTH + FLAG_W;
  logic [FLAG_W-1:0] in_flags;
  logic [DW-1:0]     rdata;
  logic              push, set_c, set_v;
  assign in_flags = pack_flags(in_negative, in_zero, in_overflow, in_carry);
  assign push     = in_valid && in_ready;
  assign set_c    = push && in_flags[FLAG_C];
  assign set_v    = push && in_flags[FLAG_V];
  assign {out_op, out_y, out_flags} = rdata;
  alu_sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data({in_op, in_y, in_flags}),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(rdata)
  );
  // a push-set event in the clear cycle survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_c  <= 1'b0;
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end else begin
      sticky_c  <= set_c || (sticky_c && !sticky_clr);
      sticky_v  <= set_v || (sticky_v && !sticky_clr);
      ovf_count <= set_v ? (sticky_clr ? CNT_W'(1) : (&ovf_count ? ovf_count : ovf_count + CNT_W'(1)))
                         : (sticky_clr ? '0 : ovf_count);
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: alu -> result stage with a scoreboard of expected beats, plus a CNT_W=2 instance for saturation
module tb_alu_result_stage;
  import alu_pkg::*;
  typedef struct packed {logic [3:0] op; logic [31:0] y; logic [3:0] f;} ent_t;
  logic clk = 0, rst = 1;
  logic [3:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic in_valid = 0, out_ready = 0, sticky_clr = 0;
  logic [31:0] alu_y;
  logic alu_c, alu_v, alu_z, alu_n;
  logic in_ready, out_valid, sticky_c, sticky_v;
  logic [3:0] out_op, out_flags;
  logic [31:0] out_y;
  logic [15:0] ovf_count;
  logic s_valid = 0;
  logic d2_in_ready, d2_out_valid, d2_sticky_c, d2_sticky_v;
  logic [3:0] d2_out_op, d2_out_flags;
  logic [31:0] d2_out_y;
  logic [1:0] d2_count;
  ent_t q[$];
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(32)) u_alu (.op(op), .a(a), .b(b), .y(alu_y), .carry(alu_c), .overflow(alu_v), .zero(alu_z), .negative(alu_n));

  alu_result_stage #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(op), .in_y(alu_y),
    .in_carry(alu_c), .in_overflow(alu_v), .in_zero(alu_z), .in_negative(alu_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_y(out_y), .out_flags(out_flags),
    .sticky_c(sticky_c), .sticky_v(sticky_v), .ovf_count(ovf_count), .sticky_clr(sticky_clr)
  );

  alu_result_stage #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(d2_in_ready), .in_op(4'h0), .in_y(32'h0),
    .in_carry(1'b0), .in_overflow(1'b1), .in_zero(1'b0), .in_negative(1'b0),
    .out_valid(d2_out_valid), .out_ready(1'b1), .out_op(d2_out_op), .out_y(d2_out_y), .out_flags(d2_out_flags),
    .sticky_c(d2_sticky_c), .sticky_v(d2_sticky_v), .ovf_count(d2_count), .sticky_clr(1'b0)
  );

  function automatic ent_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] w);
    ent_t e;
    logic [32:0] s;
    logic c, v;
    if (o == OP_SUB) begin
      e.y = x - w;
      c = x >= w;
      v = (x[31] != w[31]) && (e.y[31] != x[31]);
    end else begin
      s = {1'b0, x} + {1'b0, w};
      e.y = s[31:0];
      c = s[32];
      v = (x[31] == w[31]) && (e.y[31] != x[31]);
    end
    e.op = o;
    e.f = {e.y[31], e.y == 32'h0, v, c};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic [3:0] o, input logic [31:0] x, input logic [31:0] w, input logic clr);
    op = o; a = x; b = w; sticky_clr = clr; in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(o, x, w));
        @(posedge clk); #1;
        in_valid = 0; sticky_clr = 0;
        return;
      end
    end
    chk("push_timeout", 64'(in_ready), 64'd1);
    in_valid = 0; sticky_clr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      ent_t e;
      e = (q.size() != 0) ? q.pop_front() : 'x;
      chk("out_beat", 64'({out_op, out_y, out_flags}), 64'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst = 0;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_fields", 64'({out_op, out_y, out_flags}), 0);
    chk("rst_status", 64'({sticky_c, sticky_v, ovf_count}), 0);
    // ADD 1+1: visible one cycle after push, never the same cycle
    out_ready = 1;
    op = OP_ADD; a = 1; b = 1; in_valid = 1;
    @(negedge clk);
    chk("no_bypass", 64'(out_valid), 0);
    q.push_back(model(OP_ADD, 1, 1));
    @(posedge clk); #1;
    in_valid = 0;
    chk("lat_out_valid", 64'(out_valid), 1);
    chk("add11_y", 64'(out_y), 64'h2);
    chk("add11_flags", 64'(out_flags), 64'h0);
    chk("add11_op", 64'(out_op), 64'h0);
    push(OP_ADD, 32'hFFFFFFFF, 32'h1, 0);
    chk("addc_y", 64'(out_y), 64'h0);
    chk("addc_flags", 64'(out_flags), 64'b0101);
    chk("addc_sticky_c", 64'(sticky_c), 1);
    chk("addc_sticky_v", 64'(sticky_v), 0);
    idle(3);
    // backpressure: fill, confirm stall, then drain in order
    out_ready = 0;
    push(OP_SUB, 3, 1, 0);
    push(OP_SUB, 0, 1, 0);
    push(OP_SUB, 5, 2, 0);
    chk("bp_ready_3", 64'(in_ready), 1);
    push(OP_SUB, 10, 3, 0);
    chk("bp_ready_full", 64'(in_ready), 0);
    chk("bp_head_y", 64'(out_y), 64'h2);
    op = OP_ADD; a = 2; b = 2; in_valid = 1;
    idle(2);
    chk("bp_stall", 64'(in_ready), 0);
    chk("bp_head_held", 64'(out_y), 64'h2);
    out_ready = 1;
    push(OP_ADD, 2, 2, 0);
    idle(8);
    chk("bp_drained", 64'(out_valid), 0);
    chk("bp_queue_empty", 64'(q.size()), 0);
    chk("bp_ovf_none", 64'(ovf_count), 0);
    // overflow events and sticky clear interplay
    push(OP_ADD, 32'h7FFFFFFF, 32'h1, 0);
    push(OP_SUB, 32'h80000000, 32'h1, 0);
    chk("ovf_count2", 64'(ovf_count), 2);
    chk("ovf_sticky_v", 64'(sticky_v), 1);
    push(OP_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 1);
    chk("clr_push_count", 64'(ovf_count), 1);
    chk("clr_push_sticky_v", 64'(sticky_v), 1);
    chk("clr_push_sticky_c", 64'(sticky_c), 0);
    sticky_clr = 1;
    idle(1);
    sticky_clr = 0;
    chk("clr_count", 64'(ovf_count), 0);
    chk("clr_sticky_v", 64'(sticky_v), 0);
    idle(4);
    // reset with three entries buffered
    out_ready = 0;
    push(OP_ADD, 32'hFFFFFFFF, 32'h1, 0);
    push(OP_ADD, 32'h7FFFFFFF, 32'h1, 0);
    push(OP_SUB, 5, 2, 0);
    chk("pre_rst_status", 64'({sticky_c, sticky_v, ovf_count}), 64'({1'b1, 1'b1, 16'd1}));
    rst = 1;
    idle(1);
    rst = 0;
    q.delete();
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_in_ready", 64'(in_ready), 1);
    chk("mid_rst_fields", 64'({out_op, out_y, out_flags}), 0);
    chk("mid_rst_status", 64'({sticky_c, sticky_v, ovf_count}), 0);
    push(OP_SUB, 9, 4, 0);
    chk("post_rst_y", 64'(out_y), 64'h5);
    out_ready = 1;
    idle(3);
    chk("post_rst_alone", 64'(out_valid), 0);
    chk("post_rst_queue", 64'(q.size()), 0);
    // saturation on the 2-bit counter instance
    for (int k = 1; k <= 5; k++) begin
      s_valid = 1;
      idle(1);
      chk("sat_count", 64'(d2_count), 64'(k > 3 ? 3 : k));
    end
    s_valid = 0;
    idle(3);
    chk("sat_held", 64'(d2_count), 3);
    chk("sat_sticky", 64'({d2_sticky_c, d2_sticky_v}), 64'b01);
    chk("sat_idle", 64'({d2_in_ready, d2_out_valid}), 64'b10);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
